// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_br_taken;
  logic       halt_req;
  logic       halt_ack;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush_n;
  logic       idex_flush_n;
  logic       exmem_flush_n;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_mem_read, ex_rd, ex_br_taken, halt_req,
    input  halt_ack, pc_en, ifid_en,
    input  ifid_flush_n, idex_flush_n, exmem_flush_n
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_mem_read, ex_rd, ex_br_taken, halt_req,
    output halt_ack, pc_en, ifid_en,
    output ifid_flush_n, idex_flush_n, exmem_flush_n
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flush, debug halt drain.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_hazard_ctrl_if.slave hz_if,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    DRAIN,
    HALTED
  } state_e;

  localparam logic [2:0] CNT_INIT =
    3'(LOAD_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hz;
  logic       br;

  assign br = hz_if.ex_br_taken;

  assign hz = hz_if.ex_mem_read
            & (hz_if.ex_rd != 5'd0)
            & ((hz_if.id_use_rs1
                & (hz_if.id_rs1 == hz_if.ex_rd))
             | (hz_if.id_use_rs2
                & (hz_if.id_rs2 == hz_if.ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    hz_if.halt_ack      = 1'b0;
    hz_if.pc_en         = 1'b1;
    hz_if.ifid_en       = 1'b1;
    hz_if.ifid_flush_n  = 1'b1;
    hz_if.idex_flush_n  = 1'b1;
    hz_if.exmem_flush_n = 1'b1;
    case (state_q)
      RUN: begin
        if (br) begin
          hz_if.ifid_flush_n = 1'b0;
          hz_if.idex_flush_n = 1'b0;
        end else if (hz) begin
          hz_if.pc_en        = 1'b0;
          hz_if.ifid_en      = 1'b0;
          hz_if.idex_flush_n = 1'b0;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = LD_STALL;
            cnt_d   = CNT_INIT;
          end
        end else if (hz_if.halt_req) begin
          hz_if.pc_en        = 1'b0;
          hz_if.ifid_en      = 1'b0;
          hz_if.idex_flush_n = 1'b0;
          state_d            = DRAIN;
          cnt_d              = 3'd1;
        end
      end
      LD_STALL: begin
        hz_if.pc_en        = 1'b0;
        hz_if.ifid_en      = 1'b0;
        hz_if.idex_flush_n = 1'b0;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DRAIN: begin
        hz_if.pc_en        = 1'b0;
        hz_if.ifid_en      = 1'b0;
        hz_if.idex_flush_n = 1'b0;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        hz_if.halt_ack      = 1'b1;
        hz_if.pc_en         = 1'b0;
        hz_if.ifid_en       = 1'b0;
        hz_if.idex_flush_n  = 1'b0;
        hz_if.exmem_flush_n = 1'b0;
        if (!hz_if.halt_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
    // Reset freezes and flushes the whole front end.
    if (!reset) begin
      hz_if.halt_ack      = 1'b0;
      hz_if.pc_en         = 1'b0;
      hz_if.ifid_en       = 1'b0;
      hz_if.ifid_flush_n  = 1'b0;
      hz_if.idex_flush_n  = 1'b0;
      hz_if.exmem_flush_n = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic             stall_ev;
  logic             flush_ev;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_ev = (state_q == LD_STALL)
                  | ((state_q == RUN) & ~br & hz);
  assign flush_ev = (state_q == RUN) & br;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_ev);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_ev);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (1 and 3 stall cycles) share stimulus.
// Output vector order: {halt_ack,pc_en,ifid_en,ifid_fl_n,idex_fl_n,exmem_fl_n}.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] DEF = 6'b011111;
  localparam logic [5:0] STL = 6'b000101;
  localparam logic [5:0] BRF = 6'b011001;
  localparam logic [5:0] HLT = 6'b100100;
  localparam logic [5:0] RST = 6'b000000;

  typedef struct {
    logic [5:0]  o1;
    logic [5:0]  o3;
    bit          cc;
    int unsigned s1;
    int unsigned f1;
    int unsigned s3;
    int unsigned f3;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] sc1, fc1, sc3, fc3;

  pipeline_hazard_ctrl_if i1 ();
  pipeline_hazard_ctrl_if i3 ();

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(1),
    .CNT_W(32)
  ) u1 (
    .clk(clk),
    .reset(reset),
    .hz_if(i1.slave),
    .stall_cnt(sc1),
    .flush_cnt(fc1)
  );

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(3),
    .CNT_W(32)
  ) u3 (
    .clk(clk),
    .reset(reset),
    .hz_if(i3.slave),
    .stall_cnt(sc3),
    .flush_cnt(fc3)
  );

  exp_t        q[$];
  int          total;
  int          bad;
  int          cyc;
  bit          want_cnt;
  int unsigned w_s1, w_f1, w_s3, w_f3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs1();
    return {i1.halt_ack, i1.pc_en, i1.ifid_en,
            i1.ifid_flush_n, i1.idex_flush_n,
            i1.exmem_flush_n};
  endfunction

  function automatic logic [5:0] outs3();
    return {i3.halt_ack, i3.pc_en, i3.ifid_en,
            i3.ifid_flush_n, i3.idex_flush_n,
            i3.exmem_flush_n};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("outs_L1", 32'(outs1()), 32'(e.o1));
      chk("outs_L3", 32'(outs3()), 32'(e.o3));
      if (e.cc) begin
        chk("stall_cnt_L1", sc1, PERF ? e.s1 : 0);
        chk("flush_cnt_L1", fc1, PERF ? e.f1 : 0);
        chk("stall_cnt_L3", sc3, PERF ? e.s3 : 0);
        chk("flush_cnt_L3", fc3, PERF ? e.f3 : 0);
      end
      cyc++;
    end
  end

  task automatic expect_cnt(input int unsigned s1,
                            input int unsigned f1,
                            input int unsigned s3,
                            input int unsigned f3);
    want_cnt = 1'b1;
    w_s1 = s1;
    w_f1 = f1;
    w_s3 = s3;
    w_f3 = f3;
  endtask

  task automatic step(input bit rst,
                      input logic [4:0] rs1,
                      input logic [4:0] rs2,
                      input bit u1, input bit u2,
                      input bit mr,
                      input logic [4:0] rd,
                      input bit br, input bit hr,
                      input logic [5:0] e1,
                      input logic [5:0] e3);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    i1.id_rs1      = rs1;  i3.id_rs1      = rs1;
    i1.id_rs2      = rs2;  i3.id_rs2      = rs2;
    i1.id_use_rs1  = u1;   i3.id_use_rs1  = u1;
    i1.id_use_rs2  = u2;   i3.id_use_rs2  = u2;
    i1.ex_mem_read = mr;   i3.ex_mem_read = mr;
    i1.ex_rd       = rd;   i3.ex_rd       = rd;
    i1.ex_br_taken = br;   i3.ex_br_taken = br;
    i1.halt_req    = hr;   i3.halt_req    = hr;
    e.o1 = e1;
    e.o3 = e3;
    e.cc = want_cnt;
    e.s1 = w_s1;
    e.f1 = w_f1;
    e.s3 = w_s3;
    e.f3 = w_f3;
    want_cnt = 1'b0;
    q.push_back(e);
  endtask

  task automatic idle(input logic [5:0] e1,
                      input logic [5:0] e3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, e1, e3);
  endtask

  task automatic halt(input logic [5:0] e1,
                      input logic [5:0] e3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, e1, e3);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    want_cnt = 1'b0;
    reset    = 1'b1;
    i1.id_rs1 = '0; i1.id_rs2 = '0;
    i1.id_use_rs1 = 0; i1.id_use_rs2 = 0;
    i1.ex_mem_read = 0; i1.ex_rd = '0;
    i1.ex_br_taken = 0; i1.halt_req = 0;
    i3.id_rs1 = '0; i3.id_rs2 = '0;
    i3.id_use_rs1 = 0; i3.id_use_rs2 = 0;
    i3.ex_mem_read = 0; i3.ex_rd = '0;
    i3.ex_br_taken = 0; i3.halt_req = 0;
    #1 reset = 1'b0;

    // reset state
    expect_cnt(0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    idle(DEF, DEF);
    idle(DEF, DEF);
    // load-use on rs1
    step(1, 5, 0, 1, 0, 1, 5, 0, 0, STL, STL);
    idle(DEF, STL);
    idle(DEF, STL);
    expect_cnt(1, 0, 3, 0);
    idle(DEF, DEF);
    // x0 destination and unused rs2 never stall
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, DEF, DEF);
    step(1, 0, 7, 0, 0, 1, 7, 0, 0, DEF, DEF);
    // branch wins over hazard
    step(1, 5, 0, 1, 0, 1, 5, 1, 0, BRF, BRF);
    expect_cnt(1, 1, 3, 1);
    idle(DEF, DEF);
    // rs2 hazard, then halt arriving mid-stall
    step(1, 0, 9, 0, 1, 1, 9, 0, 0, STL, STL);
    halt(STL, STL);
    halt(STL, STL);
    halt(STL, STL);
    halt(HLT, STL);
    halt(HLT, STL);
    expect_cnt(2, 1, 6, 1);
    halt(HLT, HLT);
    idle(HLT, HLT);
    idle(DEF, DEF);
    // halt dropped during drain still completes
    halt(STL, STL);
    idle(STL, STL);
    idle(STL, STL);
    idle(HLT, HLT);
    idle(DEF, DEF);
    // reset mid-stall abandons the sequence
    step(1, 5, 0, 1, 0, 1, 5, 0, 0, STL, STL);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    expect_cnt(0, 0, 0, 0);
    idle(DEF, DEF);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, BRF, BRF);
    expect_cnt(0, 1, 0, 1);
    idle(DEF, DEF);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
